// File: rtl/lab8_soc_sysid_checker.sv
// ---------------------------------------------------------------------------
// lab8_soc_sysid_checker: reads sysid ID/timestamp over Avalon-MM and checks them.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lab8_soc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1476553823,
  parameter int unsigned TIMEOUT_CYCLES     = 255,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        error,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ID_REQ  = 3'd1;
  localparam logic [2:0] S_ID_WAIT = 3'd2;
  localparam logic [2:0] S_TS_REQ  = 3'd3;
  localparam logic [2:0] S_TS_WAIT = 3'd4;
  localparam logic [2:0] S_FINISH  = 3'd5;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam logic [2:0]  RETRY_LIMIT   = 3'(MAX_RETRIES);

  logic [2:0]  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  retry_q, retry_d;
  logic        auto_q, auto_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        error_q, error_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic in_req, in_wait, accepted, got_data, timeout, can_retry;
  logic launch, retry_event, error_event;

  always_comb begin
    in_req      = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
    in_wait     = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    accepted    = in_req && !avm_waitrequest;
    got_data    = in_wait && avm_readdatavalid;
    timeout     = (in_req || in_wait) && (timer_q == TIMEOUT_LIMIT);
    can_retry   = (retry_q < RETRY_LIMIT);
    launch      = (state_q == S_IDLE) && (start || auto_q);
    // Acceptance or data arriving on the timeout cycle wins over the timeout.
    retry_event = timeout && !accepted && !got_data && can_retry;
    error_event = timeout && !accepted && !got_data && !can_retry;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (launch) state_d = S_ID_REQ;
      S_ID_REQ:  if (accepted) state_d = S_ID_WAIT;
                 else if (error_event) state_d = S_FINISH;
      S_ID_WAIT: if (got_data) state_d = S_TS_REQ;
                 else if (retry_event) state_d = S_ID_REQ;
                 else if (error_event) state_d = S_FINISH;
      S_TS_REQ:  if (accepted) state_d = S_TS_WAIT;
                 else if (error_event) state_d = S_FINISH;
      S_TS_WAIT: if (got_data) state_d = S_FINISH;
                 else if (retry_event) state_d = S_TS_REQ;
                 else if (error_event) state_d = S_FINISH;
      // First FINISH cycle registers the verdict; the second returns to IDLE.
      S_FINISH:  if (done_q) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    avm_read    = in_req;
    avm_address = (state_q == S_TS_REQ) || (state_q == S_TS_WAIT);
    busy        = (state_q != S_IDLE);
    done        = done_q;
    id_ok       = id_ok_q;
    ts_ok       = ts_ok_q;
    error       = error_q;
    id_value    = id_value_q;
    ts_value    = ts_value_q;
  end

  always_comb begin
    timer_d    = timer_q + 16'd1;
    retry_d    = retry_q;
    auto_d     = 1'b0;
    done_d     = done_q;
    id_ok_d    = id_ok_q;
    ts_ok_d    = ts_ok_q;
    error_d    = error_q;
    id_value_d = id_value_q;
    ts_value_d = ts_value_q;

    if (!(in_req || in_wait) || (state_d != state_q) || retry_event) begin
      timer_d = 16'd0;
    end
    if (launch) begin
      retry_d = 3'd0;
      done_d  = 1'b0;
      id_ok_d = 1'b0;
      ts_ok_d = 1'b0;
      error_d = 1'b0;
    end
    if (got_data) retry_d = 3'd0;
    if (retry_event) retry_d = retry_q + 3'd1;
    if (error_event) error_d = 1'b1;
    if (got_data && (state_q == S_ID_WAIT)) id_value_d = avm_readdata;
    if (got_data && (state_q == S_TS_WAIT)) ts_value_d = avm_readdata;
    if ((state_q == S_FINISH) && !done_q) begin
      done_d  = 1'b1;
      id_ok_d = !error_q && (id_value_q == EXPECTED_ID);
      ts_ok_d = !error_q && (ts_value_q == EXPECTED_TIMESTAMP);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timer_q    <= 16'd0;
      retry_q    <= 3'd0;
      auto_q     <= AUTO_START;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      error_q    <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      timer_q    <= timer_d;
      retry_q    <= retry_d;
      auto_q     <= auto_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      error_q    <= error_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lab8_soc_sysid_checker.sv
// ---------------------------------------------------------------------------
// tb_lab8_soc_sysid_checker: randomized sysid slave plus outcome/timing model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_lab8_soc_sysid_checker;

  localparam int          TO     = 4;
  localparam int          MR     = 2;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1476553823;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, start, avm_waitrequest, avm_readdatavalid;
  logic [31:0] avm_readdata;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, error;
  logic [31:0] id_value, ts_value;

  logic        reset_n_b, start_b, wait_b, valid_b;
  logic [31:0] rdata_b;
  logic        addr_b, read_b, busy_b, done_b, id_ok_b, ts_ok_b, error_b;
  logic [31:0] idv_b, tsv_b;

  lab8_soc_sysid_checker #(
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(MR), .AUTO_START(1'b1)
  ) u_dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata), .busy(busy), .done(done), .id_ok(id_ok),
    .ts_ok(ts_ok), .error(error), .id_value(id_value), .ts_value(ts_value)
  );

  lab8_soc_sysid_checker #(
    .TIMEOUT_CYCLES(TO), .MAX_RETRIES(0), .AUTO_START(1'b0)
  ) u_dut_b (
    .clock(clock), .reset_n(reset_n_b), .start(start_b),
    .avm_address(addr_b), .avm_read(read_b),
    .avm_waitrequest(wait_b), .avm_readdatavalid(valid_b),
    .avm_readdata(rdata_b), .busy(busy_b), .done(done_b), .id_ok(id_ok_b),
    .ts_ok(ts_ok_b), .error(error_b), .id_value(idv_b), .ts_value(tsv_b)
  );

  typedef struct {
    int          stall;
    int          lat;
    bit          drop;
    logic [31:0] data;
  } plan_t;

  plan_t       plans[$];
  int          n_acc0 = 0, n_acc1 = 0, stall_err = 0;
  int          checks = 0, failures = 0;
  logic [31:0] exp_idv = 32'd0, exp_tsv = 32'd0;

  // Avalon slave: one plan per accepted read (stall cycles, latency, drop, data).
  initial begin : slave
    int          pending, stall_cnt;
    logic [31:0] pend_data;
    logic        stall_addr;
    plan_t       cur;
    pending = 0; stall_cnt = 0; pend_data = 32'd0; stall_addr = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = 32'd0;
    forever begin
      @(negedge clock);
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom();
      avm_waitrequest   = 1'b0;
      if (!reset_n) begin
        pending = 0; stall_cnt = 0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = pend_data;
          end
        end
        if (avm_read) begin
          if (plans.size() == 0) cur = '{stall: 0, lat: 1, drop: 1'b0, data: 32'hDEADBEEF};
          else cur = plans[0];
          if (stall_cnt == 0) stall_addr = avm_address;
          else if (avm_address !== stall_addr) stall_err++;
          if (stall_cnt < cur.stall) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
          end else begin
            stall_cnt = 0;
            if (plans.size() > 0) void'(plans.pop_front());
            if (avm_address) n_acc1++; else n_acc0++;
            if (!cur.drop) begin
              pending   = cur.lat;
              pend_data = cur.data;
            end
          end
        end else if (stall_cnt > 0) begin
          stall_err++;
          stall_cnt = 0;
        end
      end
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic push(input int s, input int l, input bit d, input logic [31:0] v);
    plans.push_back('{stall: s, lat: l, drop: d, data: v});
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic measure_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      tick();
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; reset_n_b = 1'b0; start = 1'b0; start_b = 1'b0;
    wait_b = 1'b0; valid_b = 1'b0; rdata_b = 32'd0;
    repeat (3) tick();
    checks++;
    if ({avm_read, avm_address, busy, done, id_ok, ts_ok, error, id_value, ts_value} !== 71'd0) begin
      failures++;
      $display("FAIL reset_main: got %h required 0",
               {avm_read, avm_address, busy, done, id_ok, ts_ok, error, id_value, ts_value});
    end
    checks++;
    if ({read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, error_b, idv_b, tsv_b} !== 71'd0) begin
      failures++;
      $display("FAIL reset_b: got %h required 0",
               {read_b, addr_b, busy_b, done_b, id_ok_b, ts_ok_b, error_b, idv_b, tsv_b});
    end
  endtask

  task automatic test_autostart;
    int n, a0, a1;
    push(0, 1, 1'b0, EXP_ID);
    push(0, 1, 1'b0, EXP_TS);
    a0 = n_acc0; a1 = n_acc1;
    reset_n = 1'b1;
    tick();
    measure_busy(n);
    exp_idv = EXP_ID; exp_tsv = EXP_TS;
    checks++;
    if (n != 6) begin failures++; $display("FAIL auto_busy_cycles: got %0d required 6", n); end
    checks++;
    if ({done, id_ok, ts_ok, error} !== 4'b1110) begin
      failures++; $display("FAIL auto_flags: got %b required 1110", {done, id_ok, ts_ok, error});
    end
    checks++;
    if ((n_acc0 - a0) != 1 || (n_acc1 - a1) != 1) begin
      failures++; $display("FAIL auto_reads: got %0d/%0d required 1/1", n_acc0 - a0, n_acc1 - a1);
    end
    checks++;
    if (id_value !== exp_idv || ts_value !== exp_tsv) begin
      failures++; $display("FAIL auto_values: got %h/%h required %h/%h", id_value, ts_value, exp_idv, exp_tsv);
    end
  endtask

  task automatic test_ts_mismatch;
    int n;
    push(0, 1, 1'b0, EXP_ID);
    push(0, 1, 1'b0, 32'h12345678);
    pulse_start();
    measure_busy(n);
    exp_idv = EXP_ID; exp_tsv = 32'h12345678;
    checks++;
    if ({done, id_ok, ts_ok, error} !== 4'b1100 || n != 6) begin
      failures++; $display("FAIL ts_mismatch_flags: got %b/%0d required 1100/6", {done, id_ok, ts_ok, error}, n);
    end
    checks++;
    if (ts_value !== 32'h12345678) begin
      failures++; $display("FAIL ts_mismatch_value: got %h required 12345678", ts_value);
    end
  endtask

  task automatic test_timeout_retry;
    int n, a0, a1;
    repeat (MR + 1) push(0, 1, 1'b1, 32'd0);
    a0 = n_acc0; a1 = n_acc1;
    pulse_start();
    measure_busy(n);
    checks++;
    if (n != (MR + 1) * (1 + TO + 1) + 2) begin
      failures++; $display("FAIL retry_busy_cycles: got %0d required %0d", n, (MR + 1) * (1 + TO + 1) + 2);
    end
    checks++;
    if ({done, id_ok, ts_ok, error} !== 4'b1001) begin
      failures++; $display("FAIL retry_flags: got %b required 1001", {done, id_ok, ts_ok, error});
    end
    checks++;
    if ((n_acc0 - a0) != MR + 1 || (n_acc1 - a1) != 0) begin
      failures++; $display("FAIL retry_reads: got %0d/%0d required %0d/0", n_acc0 - a0, n_acc1 - a1, MR + 1);
    end
    checks++;
    if (id_value !== exp_idv) begin
      failures++; $display("FAIL retry_id_hold: got %h required %h", id_value, exp_idv);
    end
  endtask

  task automatic test_waitrequest;
    int n, e0;
    push(3, 1, 1'b0, EXP_ID);
    push(3, 2, 1'b0, EXP_TS);
    e0 = stall_err;
    pulse_start();
    measure_busy(n);
    exp_idv = EXP_ID; exp_tsv = EXP_TS;
    checks++;
    if (n != 13 || stall_err != e0) begin
      failures++; $display("FAIL stall_timing: got %0d cycles %0d unstable required 13/0", n, stall_err - e0);
    end
    checks++;
    if ({done, id_ok, ts_ok, error} !== 4'b1110) begin
      failures++; $display("FAIL stall_flags: got %b required 1110", {done, id_ok, ts_ok, error});
    end
  endtask

  task automatic test_start_ignored;
    int n, a0, a1, seen;
    push(0, 1, 1'b0, EXP_ID);
    push(0, 1, 1'b0, EXP_TS);
    a0 = n_acc0; a1 = n_acc1;
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    measure_busy(n);
    seen = 0;
    repeat (10) begin
      tick();
      if (busy !== 1'b0 || avm_read !== 1'b0) seen++;
    end
    checks++;
    if (n != 4 || seen != 0) begin
      failures++; $display("FAIL start_ignored: got tail %0d restarts %0d required 4/0", n, seen);
    end
    checks++;
    if ((n_acc0 - a0) != 1 || (n_acc1 - a1) != 1 || done !== 1'b1) begin
      failures++; $display("FAIL start_ignored_reads: got %0d/%0d done %b required 1/1 done 1",
                           n_acc0 - a0, n_acc1 - a1, done);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 10; it++) begin
      int n, exp_busy, a0, a1, exp_a0, exp_a1;
      bit err, ok;
      exp_busy = 2; err = 1'b0; exp_a0 = 0; exp_a1 = 0;
      for (int addr = 0; addr < 2; addr++) begin
        if (!err) begin
          ok = 1'b0;
          for (int at = 0; at <= MR && !ok; at++) begin
            int s, l;
            bit d;
            logic [31:0] v;
            s = $urandom_range(0, TO - 1);
            l = $urandom_range(1, TO + 1);
            d = ($urandom_range(0, 3) == 0);
            v = $urandom_range(0, 1) ? (addr == 0 ? EXP_ID : EXP_TS) : $urandom();
            push(s, l, d, v);
            if (addr == 0) exp_a0++; else exp_a1++;
            if (d) exp_busy += s + 1 + TO + 1;
            else begin
              exp_busy += s + 1 + l;
              ok = 1'b1;
              if (addr == 0) exp_idv = v; else exp_tsv = v;
            end
          end
          if (!ok) err = 1'b1;
        end
      end
      a0 = n_acc0; a1 = n_acc1;
      pulse_start();
      measure_busy(n);
      checks++;
      if (n != exp_busy) begin
        failures++; $display("FAIL rand%0d_busy_cycles: got %0d required %0d", it, n, exp_busy);
      end
      checks++;
      if ({done, id_ok, ts_ok, error} !== {1'b1, !err && exp_idv == EXP_ID, !err && exp_tsv == EXP_TS, err}) begin
        failures++; $display("FAIL rand%0d_flags: got %b required %b", it, {done, id_ok, ts_ok, error},
                             {1'b1, !err && exp_idv == EXP_ID, !err && exp_tsv == EXP_TS, err});
      end
      checks++;
      if (id_value !== exp_idv || ts_value !== exp_tsv ||
          (n_acc0 - a0) != exp_a0 || (n_acc1 - a1) != exp_a1) begin
        failures++; $display("FAIL rand%0d_values: got %h/%h reads %0d/%0d required %h/%h reads %0d/%0d", it,
                             id_value, ts_value, n_acc0 - a0, n_acc1 - a1, exp_idv, exp_tsv, exp_a0, exp_a1);
      end
    end
  endtask

  task automatic test_reset_mid;
    int n, g, a0, a1, seen;
    push(0, 1, 1'b0, EXP_ID);
    repeat (MR + 1) push(0, 1, 1'b1, 32'd0);
    a1 = n_acc1;
    pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    g = 0;
    while (n_acc1 == a1 && g < 50) begin tick(); g++; end
    tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({avm_read, avm_address, busy, done, id_ok, ts_ok, error, id_value, ts_value} !== 71'd0 || g >= 50) begin
      failures++;
      $display("FAIL reset_mid_async: got %h (wait %0d) required 0",
               {avm_read, avm_address, busy, done, id_ok, ts_ok, error, id_value, ts_value}, g);
    end
    plans.delete();
    exp_idv = 32'd0; exp_tsv = 32'd0;
    a0 = n_acc0; a1 = n_acc1; seen = 0;
    repeat (5) begin
      tick();
      if (avm_read !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0 || n_acc0 != a0 || n_acc1 != a1) begin
      failures++; $display("FAIL reset_mid_quiet: got %0d active cycles required 0", seen);
    end
    push(0, 1, 1'b0, EXP_ID);
    push(0, 1, 1'b0, EXP_TS);
    reset_n = 1'b1;
    tick();
    measure_busy(n);
    exp_idv = EXP_ID; exp_tsv = EXP_TS;
    checks++;
    if (n != 6 || {done, id_ok, ts_ok, error} !== 4'b1110) begin
      failures++; $display("FAIL reset_mid_restart: got %0d/%b required 6/1110", n, {done, id_ok, ts_ok, error});
    end
  endtask

  task automatic test_no_autostart;
    int n, seen;
    reset_n_b = 1'b1;
    seen = 0;
    repeat (20) begin
      tick();
      if (read_b !== 1'b0 || busy_b !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL b_no_autostart: got %0d active cycles required 0", seen);
    end
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    checks++;
    if ({read_b, addr_b, busy_b} !== 3'b101) begin
      failures++; $display("FAIL b_first_read: got %b required 101", {read_b, addr_b, busy_b});
    end
    n = 0;
    while (busy_b === 1'b1 && n < 2000) begin n++; tick(); end
    checks++;
    if (n != 1 + TO + 1 + 2 || {done_b, id_ok_b, ts_ok_b, error_b} !== 4'b1001) begin
      failures++; $display("FAIL b_no_retry_error: got %0d/%b required %0d/1001",
                           n, {done_b, id_ok_b, ts_ok_b, error_b}, 1 + TO + 1 + 2);
    end
  endtask

  initial begin
    test_reset();
    test_autostart();
    test_ts_mismatch();
    test_timeout_retry();
    test_waitrequest();
    test_start_ignored();
    test_random();
    test_reset_mid();
    test_no_autostart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lab8_soc_sysid_checker.md
LAB8_SOC_SYSID_CHECKER -- requirements
Module: lab8_soc_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 0: value required at sysid address 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 1476553823: value required at sysid address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 255: maximum wait cycles per read, range 1..65535.
REQ-004 Parameter MAX_RETRIES, default 3: re-issues allowed per read after a timeout, range 0..7.
REQ-005 Parameter AUTO_START, default 1: when 1, a check starts automatically on the first cycle after reset release.
REQ-006 Port: clock, input, 1, sole clock; all logic on rising edge.
REQ-007 Port: reset_n, input, 1, asynchronous active-low reset.
REQ-008 Port: start, input, 1, single-cycle request to run a check.
REQ-009 Port: avm_address, output, 1, word address to sysid (0 = ID, 1 = timestamp).
REQ-010 Port: avm_read, output, 1, Avalon-MM read request.
REQ-011 Port: avm_waitrequest, input, 1, slave stall; read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-012 Port: avm_readdatavalid, input, 1, qualifies avm_readdata.
REQ-013 Port: avm_readdata, input, 32, read data from sysid.
REQ-014 Port: busy, output, 1, high while a check is in progress.
REQ-015 Port: done, output, 1, sticky completion flag.
REQ-016 Port: id_ok, output, 1, captured ID equals EXPECTED_ID.
REQ-017 Port: ts_ok, output, 1, captured timestamp equals EXPECTED_TIMESTAMP.
REQ-018 Port: error, output, 1, a read exhausted its retries.
REQ-019 Port: id_value, output, 32, last captured ID word.
REQ-020 Port: ts_value, output, 32, last captured timestamp word.

Function
REQ-021 The FSM SHALL have states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and FINISH.
REQ-022 IDLE -> ID_REQ on start=1 or on the AUTO_START first cycle; entry clears done, id_ok, ts_ok, error and the retry counter.
REQ-023 In ID_REQ/TS_REQ: avm_read=1 and avm_address=0 or 1 respectively; hold until accepted, then move to ID_WAIT/TS_WAIT with avm_read=0 on the next cycle.
REQ-024 In *_WAIT: capture avm_readdata into id_value/ts_value on the first cycle with avm_readdatavalid=1; ID_WAIT -> TS_REQ, TS_WAIT -> FINISH; retry counter cleared.
REQ-025 avm_readdatavalid is ignored outside *_WAIT states; the slave read latency is at least 1 cycle.
REQ-026 A 16-bit timeout counter SHALL run in *_REQ and *_WAIT; it clears on every state change and on every retry.
REQ-027 Timeout fires when the counter reaches TIMEOUT_CYCLES. If retries < MAX_RETRIES, increment retries and return to the same *_REQ. Otherwise set error=1 and go to FINISH.
REQ-028 In FINISH: id_ok=(id_value==EXPECTED_ID) and ts_ok=(ts_value==EXPECTED_TIMESTAMP), both forced 0 if error=1. Set done=1 and go to IDLE one cycle later.
REQ-029 busy=1 in every state except IDLE.
REQ-030 done, id_ok, ts_ok and error hold their values until the next check starts.
REQ-031 start while busy=1 SHALL be ignored and not queued.
REQ-032 avm_readdatavalid coinciding with a timeout SHALL count as valid data; no retry occurs.
REQ-033 avm_read SHALL never be 1 in any *_WAIT, IDLE or FINISH state.

Reset
REQ-034 reset_n=0 SHALL immediately force state IDLE, avm_read=0, avm_address=0, busy=0, done=0, id_ok=0, ts_ok=0, error=0, id_value=0, ts_value=0 and clear all counters.
REQ-035 Reset asserted mid-operation SHALL abort the check with no further bus activity.
REQ-036 After release, a new check starts only on start or AUTO_START.

Verification
REQ-037 AUTO_START=1; slave returns 0 then 1476553823 at latency 1 with no waitrequest -> two reads, done=1, id_ok=1, ts_ok=1, error=0, busy high for exactly 6 cycles.
REQ-038 Slave returns timestamp 0x12345678 -> done=1, id_ok=1, ts_ok=0, ts_value=0x12345678, error=0.
REQ-039 TIMEOUT_CYCLES=4, MAX_RETRIES=2, slave never asserts readdatavalid for address 0 -> three ID read issues, then error=1, done=1, id_ok=0, ts_ok=0, no address-1 read.
REQ-040 avm_waitrequest=1 for 3 cycles on each read -> avm_read and avm_address stable while stalled; check passes with id_ok=ts_ok=1.
REQ-041 Pulse start while busy, then assert reset_n=0 during TS_WAIT -> extra start ignored; all outputs 0 asynchronously; no read until the next start.
